// File: rtl/rib_arbiter.sv
// Round-robin arbiter and grant sequencer for the shared RIB bus.
// Three masters (core data, debug, DMA) share one single-beat slave port.
module rib_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_rdata_o,

  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_rdata_o,

  input  logic              m2_req_i,
  input  logic              m2_we_i,
  input  logic [ADDR_W-1:0] m2_addr_i,
  input  logic [DATA_W-1:0] m2_wdata_i,
  output logic              m2_gnt_o,
  output logic              m2_ack_o,
  output logic [DATA_W-1:0] m2_rdata_o,

  output logic              s_req_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_wdata_o,
  input  logic [DATA_W-1:0] s_rdata_i,
  input  logic              s_ack_i,

  output logic              rib_hold_flag_o
);

  localparam int unsigned     CntW    = $clog2(MAX_HOLD) + 1;
  localparam logic [CntW-1:0] MaxHold = CntW'(MAX_HOLD);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [1:0]      owner_q, owner_d;
  logic [1:0]      last_q, last_d;
  logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
  logic [2:0]      gnt_q, gnt_d;

  logic [2:0]        req;
  logic [2:0]        we;
  logic [ADDR_W-1:0] addr  [3];
  logic [DATA_W-1:0] wdata [3];

  assign req      = {m2_req_i, m1_req_i, m0_req_i};
  assign we       = {m2_we_i, m1_we_i, m0_we_i};
  assign addr[0]  = m0_addr_i;
  assign addr[1]  = m1_addr_i;
  assign addr[2]  = m2_addr_i;
  assign wdata[0] = m0_wdata_i;
  assign wdata[1] = m1_wdata_i;
  assign wdata[2] = m2_wdata_i;

  // An owner code of 3 never qualifies as busy, so it falls back to idle behaviour.
  logic       busy;
  logic [2:0] own_oh;

  assign busy = (state_q == StBusy) && (owner_q != 2'd3);

  always_comb begin
    own_oh = 3'b000;
    if (busy) begin
      case (owner_q)
        2'd0:    own_oh = 3'b001;
        2'd1:    own_oh = 3'b010;
        2'd2:    own_oh = 3'b100;
        default: own_oh = 3'b000;
      endcase
    end
  end

  // Slave-side mux: AND-OR of the owner's inputs, all zero when idle.
  always_comb begin
    s_req_o   = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    for (int i = 0; i < 3; i++) begin
      s_req_o   = s_req_o | (own_oh[i] & req[i]);
      s_we_o    = s_we_o | (own_oh[i] & we[i]);
      s_addr_o  = s_addr_o | ({ADDR_W{own_oh[i]}} & addr[i]);
      s_wdata_o = s_wdata_o | ({DATA_W{own_oh[i]}} & wdata[i]);
    end
  end

  logic complete;
  logic owner_req;
  logic others_req;

  assign complete   = s_req_o & s_ack_i;
  assign owner_req  = |(own_oh & req);
  assign others_req = |(req & ~own_oh);

  assign m0_ack_o   = own_oh[0] & complete;
  assign m1_ack_o   = own_oh[1] & complete;
  assign m2_ack_o   = own_oh[2] & complete;
  assign m0_rdata_o = {DATA_W{own_oh[0]}} & s_rdata_i;
  assign m1_rdata_o = {DATA_W{own_oh[1]}} & s_rdata_i;
  assign m2_rdata_o = {DATA_W{own_oh[2]}} & s_rdata_i;

  assign m0_gnt_o = gnt_q[0];
  assign m1_gnt_o = gnt_q[1];
  assign m2_gnt_o = gnt_q[2];

  // Combinational so the core stalls in the very cycle it raises a request.
  assign rib_hold_flag_o = m0_req_i & ~own_oh[0];

  // Round-robin search order: last+1, last+2, last (mod 3).
  logic [1:0] cand0, cand1, cand2;
  logic [1:0] pick;
  logic [2:0] pick_oh;

  always_comb begin
    case (last_q)
      2'd0:    begin cand0 = 2'd1; cand1 = 2'd2; cand2 = 2'd0; end
      2'd1:    begin cand0 = 2'd2; cand1 = 2'd0; cand2 = 2'd1; end
      default: begin cand0 = 2'd0; cand1 = 2'd1; cand2 = 2'd2; end
    endcase
  end

  always_comb begin
    pick = cand2;
    if (req[cand0]) begin
      pick = cand0;
    end else if (req[cand1]) begin
      pick = cand1;
    end
    case (pick)
      2'd0:    pick_oh = 3'b001;
      2'd1:    pick_oh = 3'b010;
      default: pick_oh = 3'b100;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    if (!busy) begin
      state_d = StIdle;
      gnt_d   = 3'b000;
      if (|req) begin
        state_d    = StBusy;
        owner_d    = pick;
        hold_cnt_d = '0;
        gnt_d      = pick_oh;
      end
    end else if (!owner_req) begin
      // Normal end of tenure, or a request withdrawn without ack.
      state_d = StIdle;
      gnt_d   = 3'b000;
      last_d  = owner_q;
    end else if (complete) begin
      if (hold_cnt_q != MaxHold) begin
        hold_cnt_d = hold_cnt_q + CntW'(1);
      end
      if ((hold_cnt_q >= MaxHold - CntW'(1)) && others_req) begin
        state_d = StIdle;
        gnt_d   = 3'b000;
        last_d  = owner_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_q    <= 2'd0;
      last_q     <= 2'd2;
      hold_cnt_q <= '0;
      gnt_q      <= 3'b000;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
    end
  end

endmodule

// File: tb/tb_rib_arbiter.sv
// Scoreboard bench for rib_arbiter: a per-cycle reference model predicts bus
// ownership and completed transactions; a monitor matches acks against the queue.
module tb_rib_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    req;
  logic [2:0]    we;
  logic [AW-1:0] addr  [3];
  logic [DW-1:0] wdata [3];
  logic          s_ack;
  logic [DW-1:0] s_rdata;

  logic          m0_gnt, m1_gnt, m2_gnt, m0_ack, m1_ack, m2_ack;
  logic [DW-1:0] m0_rdata, m1_rdata, m2_rdata;
  logic          s_req, s_we, hold;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;

  rib_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(req[0]), .m0_we_i(we[0]), .m0_addr_i(addr[0]), .m0_wdata_i(wdata[0]),
    .m0_gnt_o(m0_gnt), .m0_ack_o(m0_ack), .m0_rdata_o(m0_rdata),
    .m1_req_i(req[1]), .m1_we_i(we[1]), .m1_addr_i(addr[1]), .m1_wdata_i(wdata[1]),
    .m1_gnt_o(m1_gnt), .m1_ack_o(m1_ack), .m1_rdata_o(m1_rdata),
    .m2_req_i(req[2]), .m2_we_i(we[2]), .m2_addr_i(addr[2]), .m2_wdata_i(wdata[2]),
    .m2_gnt_o(m2_gnt), .m2_ack_o(m2_ack), .m2_rdata_o(m2_rdata),
    .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
    .s_rdata_i(s_rdata), .s_ack_i(s_ack),
    .rib_hold_flag_o(hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            m;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
  } txn_t;

  txn_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model state: is the bus owned, by whom, who owned it last, beats done.
  bit       mb;
  int       mo, ml, mc;
  bit [2:0] comp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mb = 0; mo = 0; ml = 2; mc = 0;
  endtask

  task automatic new_txn(input int i, input bit force_write);
    req[i]   = 1'b1;
    we[i]    = force_write ? 1'b1 : 1'($urandom);
    addr[i]  = $urandom;
    wdata[i] = $urandom;
  endtask

  task automatic step();
    logic [2:0]    eg, ea;
    logic [DW-1:0] erd [3];
    bit            found;
    bit            others;
    @(negedge clk);
    comp = 3'b000;
    for (int i = 0; i < 3; i++) begin
      eg[i]  = mb && (mo == i);
      ea[i]  = mb && (mo == i) && req[i] && s_ack;
      erd[i] = (mb && mo == i) ? s_rdata : '0;
    end
    chk("gnt", {m2_gnt, m1_gnt, m0_gnt}, eg);
    chk("ack", {m2_ack, m1_ack, m0_ack}, ea);
    chk("hold_flag", hold, req[0] && !(mb && mo == 0));
    chk("s_req", s_req, mb && req[mo]);
    chk("s_we", s_we, mb ? we[mo] : 1'b0);
    chk("s_addr", s_addr, mb ? addr[mo] : '0);
    chk("s_wdata", s_wdata, mb ? wdata[mo] : '0);
    chk("m0_rdata", m0_rdata, erd[0]);
    chk("m1_rdata", m1_rdata, erd[1]);
    chk("m2_rdata", m2_rdata, erd[2]);
    if (mb && req[mo] && s_ack) begin
      comp[mo] = 1'b1;
      sb.push_back('{m: mo, we: we[mo], a: addr[mo], wd: wdata[mo], rd: s_rdata});
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (!mb) begin
      found = 0;
      for (int k = 1; k <= 3; k++) begin
        if (!found && req[(ml + k) % 3]) begin
          found = 1; mb = 1; mo = (ml + k) % 3; mc = 0;
        end
      end
    end else if (!req[mo]) begin
      mb = 0; ml = mo;
    end else if (s_ack) begin
      others = 0;
      for (int i = 0; i < 3; i++) if (i != mo && req[i]) others = 1;
      if (mc + 1 >= MH && others) begin
        mb = 0; ml = mo;
      end
      mc = (mc + 1 > MH) ? MH : mc + 1;
    end
    #1;
  endtask

  // Monitor: every master ack must match the oldest predicted completion.
  initial begin
    txn_t t;
    forever begin
      @(negedge clk);
      #2;
      if ({m2_ack, m1_ack, m0_ack} != 3'b000) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_unexpected_ack: got acks %b expected none", {m2_ack, m1_ack, m0_ack});
        end else begin
          t = sb.pop_front();
          chk("sb_master", {m2_ack, m1_ack, m0_ack}, 3'b001 << t.m);
          chk("sb_we", s_we, t.we);
          chk("sb_addr", s_addr, t.a);
          chk("sb_wdata", s_wdata, t.wd);
          chk("sb_rdata", (t.m == 0) ? m0_rdata : (t.m == 1) ? m1_rdata : m2_rdata, t.rd);
        end
      end else if (sb.size() != 0) begin
        t = sb.pop_front();
        checks++; failures++;
        $display("FAIL sb_missing_ack: got no ack expected ack for master %0d", t.m);
      end
    end
  end

  initial begin
    int beats;
    req = 3'b000; we = 3'b000; s_ack = 1'b0; s_rdata = '0;
    for (int i = 0; i < 3; i++) begin addr[i] = '0; wdata[i] = '0; end
    model_reset();

    // Reset with m0 requesting.
    new_txn(0, 0);
    #3;
    chk("rst_hold_flag", hold, 1'b1);
    chk("rst_gnt", {m2_gnt, m1_gnt, m0_gnt}, 3'b000);
    chk("rst_s_req", s_req, 1'b0);
    step(); step();
    rst = 1'b0;
    step();
    #3;
    chk("first_gnt_m0", m0_gnt, 1'b1);
    chk("first_hold_low", hold, 1'b0);
    chk("first_s_addr", s_addr, addr[0]);
    s_ack = 1'b1; s_rdata = $urandom;
    step();
    req = 3'b000; s_ack = 1'b0;
    step(); step();

    // All three continuously requesting with s_ack held high.
    for (int i = 0; i < 3; i++) new_txn(i, 0);
    s_ack = 1'b1;
    for (int c = 0; c < 16; c++) begin
      s_rdata = $urandom;
      step();
      for (int i = 0; i < 3; i++) if (comp[i]) new_txn(i, 0);
    end
    req = 3'b000; s_ack = 1'b0;
    step(); step();

    // m1 owns with a stalled slave while m0 waits.
    new_txn(1, 0);
    step();
    new_txn(0, 0);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("stall_hold_flag", hold, 1'b1);
    end
    s_ack = 1'b1; s_rdata = 32'hDEADBEEF;
    #3;
    chk("beef_rdata", m1_rdata, 32'hDEADBEEF);
    chk("beef_ack", m1_ack, 1'b1);
    chk("beef_m0_ack", m0_ack, 1'b0);
    step();
    req[1] = 1'b0; s_ack = 1'b0;
    step(); step(); step();
    s_ack = 1'b1;
    step();
    req = 3'b000; s_ack = 1'b0;
    step(); step();

    // Single requester m2: 40 back-to-back writes with no bubbles.
    new_txn(2, 1);
    s_ack = 1'b1;
    step();
    beats = 0;
    for (int c = 0; c < 40; c++) begin
      #2;
      chk("m2_no_bubble", {m2_gnt, s_req}, 2'b11);
      s_rdata = $urandom;
      step();
      if (comp[2]) begin beats++; new_txn(2, 1); end
    end
    chk("m2_beats", beats, 40);
    req = 3'b000; s_ack = 1'b0;
    step(); step();

    // Asynchronous reset while m0 is mid-transaction, then m0+m1+m2 request.
    new_txn(0, 0);
    step(); step();
    #1 rst = 1'b1;
    #1;
    chk("async_gnt", {m2_gnt, m1_gnt, m0_gnt}, 3'b000);
    chk("async_s_req", {s_req, s_we}, 2'b00);
    chk("async_s_addr", s_addr, '0);
    chk("async_m0_rdata", m0_rdata, '0);
    model_reset();
    step();
    rst = 1'b0;
    new_txn(1, 0); new_txn(2, 0);
    step();
    #3;
    chk("post_rst_m0_first", {m2_gnt, m1_gnt, m0_gnt}, 3'b001);
    step();

    // Reset again; only m1+m2 request, m1 should win.
    #1 rst = 1'b1;
    model_reset();
    req[0] = 1'b0;
    step();
    rst = 1'b0;
    step();
    #3;
    chk("post_rst_m1_first", {m2_gnt, m1_gnt, m0_gnt}, 3'b010);
    step();

    // Owner drops its request without an ack.
    req[1] = 1'b0; s_ack = 1'b1;
    step();
    #3;
    chk("drop_idle", {m2_gnt, m1_gnt, m0_gnt}, 3'b000);
    step();
    #3;
    chk("drop_next_m2", m2_gnt, 1'b1);
    step();
    req = 3'b000; s_ack = 1'b0;
    step(); step();

    // Randomised traffic, including occasional protocol-violating drops.
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < 3; i++) begin
        if (req[i]) begin
          if (comp[i]) begin
            if ($urandom_range(1, 0) == 1) new_txn(i, 0);
            else req[i] = 1'b0;
          end else if ($urandom_range(49, 0) == 0) begin
            req[i] = 1'b0;
          end
        end else if ($urandom_range(2, 0) == 0) begin
          new_txn(i, 0);
        end
      end
      s_ack   = ($urandom_range(2, 0) != 0);
      s_rdata = $urandom;
    end
    req = 3'b000;
    step(); step();
    #5;
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
